serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: D = A - B - bin.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B - bin.
// One full-subtractor cell and a borrow flop handle one bit per clock, LSB first.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ready; waiting for start, holds the previous result
// ST_SHIFT | one bit per clock, cnt = bit index currently processed
// ST_DONE  | one-cycle done strobe, diff/bout/ovf freshly valid
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_di;
  logic             w_brw_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;
  logic             w_ovf_nxt;

  // Full-subtractor cell; operand LSBs hold the current bit since the regs shift right.
  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_di      = w_ai ^ w_bi ^ r_brw;
  assign w_brw_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);
  assign w_res_nxt = {w_di, r_res[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  // On the last bit the LSBs of the operand regs are the loaded MSBs.
  assign w_ovf_nxt = (w_ai != w_bi) && (w_di != w_ai);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_brw   <= bus.bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_res <= w_res_nxt;
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_brw <= w_brw_nxt;
          if (w_last) begin
            r_diff  <= w_res_nxt;
            r_bout  <= w_brw_nxt;
            r_ovf   <= w_ovf_nxt;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.bout  = r_bout;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic/timeline model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    int s;
    r  = int'(a) - int'(b) - int'(bi);
    d  = r[W-1:0];
    bo = (r < 0);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  // Model: m_k = cycles since the accepting edge, -1 when idle.
  int           m_k    = -1;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] p_diff;
  logic         p_bout;
  logic         p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k    = -1;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_k < 0) begin
      if (bus.start) begin
        ref_sub(bus.a, bus.b, bus.bin, p_diff, p_bout, p_ovf);
        m_k = 1;
      end
    end else if (m_k == W + 1) begin
      m_k = -1;
    end else begin
      m_k++;
      if (m_k == W + 1) begin
        m_diff = p_diff;
        m_bout = p_bout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    chk("model ready", int'(bus.ready), int'(m_k < 0));
    chk("model busy",  int'(bus.busy),  int'(m_k >= 1 && m_k <= W));
    chk("model done",  int'(bus.done),  int'(m_k == W + 1));
    chk("model diff",  int'(bus.diff),  int'(m_diff));
    chk("model bout",  int'(bus.bout),  int'(m_bout));
    chk("model ovf",   int'(bus.ovf),   int'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.ready && n < 30) begin
      tick();
      n++;
    end
    chk({nm, " ready wait"}, int'(bus.ready), 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input string nm, input logic [W-1:0] ed, input logic eb,
                        input logic eo);
    int n;
    wait_ready(nm);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    n = 1;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, n, W + 1);
    chk({nm, " diff"}, int'(bus.diff), int'(ed));
    chk({nm, " bout"}, int'(bus.bout), int'(eb));
    chk({nm, " ovf"},  int'(bus.ovf),  int'(eo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int ndone;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    tick();
    tick();
    chk("reset ready", int'(bus.ready), 1);
    chk("reset busy",  int'(bus.busy),  0);
    chk("reset done",  int'(bus.done),  0);
    chk("reset diff",  int'(bus.diff),  0);
    rst_n = 1'b1;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, "T1",      8'h1E, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, "T2a",     8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, "T2b",     8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, "T3a",     8'h80, 1'b1, 1'b1);
    run_op(8'h10, 8'h0F, 1'b1, "T3b",     8'h00, 1'b0, 1'b0);
    run_op(8'hA5, 8'hA5, 1'b1, "eq_bin",  8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h00, 1'b1, "neg_ovf", 8'h7F, 1'b0, 1'b1);

    // T4: starts during SHIFT and DONE must be ignored
    wait_ready("T4");
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.bin   = 1'b0;
    tick();
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= W + 1) chk("T4 ready low", int'(bus.ready), 0);
      if (bus.done) begin
        ndone++;
        chk("T4 diff", int'(bus.diff), 8'h22);
      end
      bus.start = (c == 3 || c == W + 1);
      bus.a     = 8'hFF;
      bus.b     = 8'h01;
      bus.bin   = 1'b1;
      tick();
    end
    chk("T4 done count", ndone, 1);

    // T5: asynchronous abort mid-operation
    wait_ready("T5");
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("T5 ready", int'(bus.ready), 1);
    chk("T5 busy",  int'(bus.busy),  0);
    chk("T5 diff",  int'(bus.diff),  0);
    chk("T5 done",  int'(bus.done),  0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("T5 no done", ndone, 0);
    run_op(8'h5A, 8'h3C, 1'b0, "T5 fresh", 8'h1E, 1'b0, 1'b0);

    // T6: start held high, random operands every cycle
    wait_ready("T6");
    bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 256 * (W + 2); i++) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom);
      tick();
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    chk("T6 done count", ndone, 256);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
